// File: rtl/cart_bus_master_if.sv
// Request/response handshake between a requester and the cartridge bus initiator.
// The requester uses the master modport and cart_bus_master uses the slave modport.
interface cart_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_ppu;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (
    output req_valid, req_ppu, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_ppu, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cart_bus_master.sv
// Famicom cartridge bus initiator: produces phased M2, /ROMSEL, R/W, address and data cycles
// on the CPU bus and /RD, /WR strobe cycles on the PPU bus. M2 free-runs, so it keeps toggling when idle.
module cart_bus_master #(
  parameter int M2_LOW_CYCLES  = 4,
  parameter int M2_HIGH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  cart_bus_master_if.slave bus,
  output logic             m2,
  output logic             romsel,
  output logic             cpu_rw,
  output logic [14:0]      cpu_addr,
  output logic [7:0]       cpu_data_out,
  output logic             cpu_data_oe,
  input  logic [7:0]       cpu_data_in,
  output logic             ppu_rd,
  output logic             ppu_wr,
  output logic [13:0]      ppu_addr,
  output logic             ppu_not_a13,
  output logic [7:0]       ppu_data_out,
  output logic             ppu_data_oe,
  input  logic [7:0]       ppu_data_in
);
  localparam int T    = M2_LOW_CYCLES + M2_HIGH_CYCLES;
  localparam int PH_W = $clog2(T);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(T - 1);
  localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(M2_LOW_CYCLES);
  localparam logic [PH_W-1:0] PH_STROBE = PH_W'(2);

  typedef enum logic [1:0] {IDLE, CPU, PPU} state_t;

  state_t          state_reg, state_next;
  logic [PH_W-1:0] ph_reg, ph_next;
  logic            write_reg, write_next;
  logic            a15_reg, a15_next;
  logic            m2_reg, m2_next;
  logic            romsel_reg, romsel_next;
  logic            cpu_rw_reg, cpu_rw_next;
  logic [14:0]     cpu_addr_reg, cpu_addr_next;
  logic [7:0]      cpu_dout_reg, cpu_dout_next;
  logic            cpu_oe_reg, cpu_oe_next;
  logic            ppu_rd_reg, ppu_rd_next;
  logic            ppu_wr_reg, ppu_wr_next;
  logic [13:0]     ppu_addr_reg, ppu_addr_next;
  logic            ppu_na13_reg, ppu_na13_next;
  logic [7:0]      ppu_dout_reg, ppu_dout_next;
  logic            ppu_oe_reg, ppu_oe_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [7:0]      rsp_rdata_reg, rsp_rdata_next;
  logic            accept;
  logic            done;

  always_comb begin
    ph_next        = (ph_reg == PH_LAST) ? '0 : ph_reg + PH_W'(1);
    accept         = bus.req_valid & (ph_reg == '0);
    state_next     = state_reg;
    write_next     = write_reg;
    a15_next       = a15_reg;
    cpu_rw_next    = cpu_rw_reg;
    cpu_addr_next  = cpu_addr_reg;
    cpu_dout_next  = cpu_dout_reg;
    cpu_oe_next    = cpu_oe_reg;
    ppu_addr_next  = ppu_addr_reg;
    ppu_na13_next  = ppu_na13_reg;
    ppu_dout_next  = ppu_dout_reg;
    ppu_oe_next    = ppu_oe_reg;
    rsp_rdata_next = rsp_rdata_reg;

    // Period boundary: the previous transaction releases here and bus controls go idle
    // unless a new request is being loaded for the coming ph = 1.
    if (ph_reg == '0) begin
      state_next  = IDLE;
      cpu_rw_next = 1'b1;
      cpu_oe_next = 1'b0;
      ppu_oe_next = 1'b0;
      if (accept) begin
        write_next = bus.req_write;
        if (bus.req_ppu) begin
          state_next    = PPU;
          ppu_addr_next = bus.req_addr[13:0];
          ppu_na13_next = ~bus.req_addr[13];
          ppu_dout_next = bus.req_wdata;
          ppu_oe_next   = bus.req_write;
        end else begin
          state_next    = CPU;
          a15_next      = bus.req_addr[15];
          cpu_addr_next = bus.req_addr[14:0];
          cpu_rw_next   = ~bus.req_write;
          cpu_dout_next = bus.req_wdata;
          cpu_oe_next   = bus.req_write;
        end
      end
    end

    m2_next     = (ph_next >= PH_HIGH);
    romsel_next = ~(m2_next & a15_next & (state_next == CPU));
    ppu_rd_next = ~((state_next == PPU) & ~write_next & (ph_next >= PH_STROBE));
    ppu_wr_next = ~((state_next == PPU) &  write_next & (ph_next >= PH_STROBE));

    // The edge leaving ph = T-1 ends M2-high / the PPU strobe: sample read data here.
    done           = (ph_reg == PH_LAST) & (state_reg != IDLE);
    rsp_valid_next = done;
    if (done & ~write_reg)
      rsp_rdata_next = (state_reg == PPU) ? ppu_data_in : cpu_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ph_reg        <= '0;
      write_reg     <= 1'b0;
      a15_reg       <= 1'b0;
      m2_reg        <= 1'b0;
      romsel_reg    <= 1'b1;
      cpu_rw_reg    <= 1'b1;
      cpu_addr_reg  <= '0;
      cpu_dout_reg  <= '0;
      cpu_oe_reg    <= 1'b0;
      ppu_rd_reg    <= 1'b1;
      ppu_wr_reg    <= 1'b1;
      ppu_addr_reg  <= '0;
      ppu_na13_reg  <= 1'b1;
      ppu_dout_reg  <= '0;
      ppu_oe_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ph_reg        <= ph_next;
      write_reg     <= write_next;
      a15_reg       <= a15_next;
      m2_reg        <= m2_next;
      romsel_reg    <= romsel_next;
      cpu_rw_reg    <= cpu_rw_next;
      cpu_addr_reg  <= cpu_addr_next;
      cpu_dout_reg  <= cpu_dout_next;
      cpu_oe_reg    <= cpu_oe_next;
      ppu_rd_reg    <= ppu_rd_next;
      ppu_wr_reg    <= ppu_wr_next;
      ppu_addr_reg  <= ppu_addr_next;
      ppu_na13_reg  <= ppu_na13_next;
      ppu_dout_reg  <= ppu_dout_next;
      ppu_oe_reg    <= ppu_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign bus.req_ready = (ph_reg == '0) & ~rst;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign m2            = m2_reg;
  assign romsel        = romsel_reg;
  assign cpu_rw        = cpu_rw_reg;
  assign cpu_addr      = cpu_addr_reg;
  assign cpu_data_out  = cpu_dout_reg;
  assign cpu_data_oe   = cpu_oe_reg;
  assign ppu_rd        = ppu_rd_reg;
  assign ppu_wr        = ppu_wr_reg;
  assign ppu_addr      = ppu_addr_reg;
  assign ppu_not_a13   = ppu_na13_reg;
  assign ppu_data_out  = ppu_dout_reg;
  assign ppu_data_oe   = ppu_oe_reg;
endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master with default 4/4 M2 timing; each transaction records
// eight per-clk samples (ph 1..7 then ph 0) as bit vectors and compares them to hand-computed patterns.
module tb_cart_bus_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m2, romsel, cpu_rw, cpu_data_oe, ppu_rd, ppu_wr, ppu_not_a13, ppu_data_oe;
  logic [14:0] cpu_addr;
  logic [13:0] ppu_addr;
  logic [7:0]  cpu_data_out, ppu_data_out;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  ppu_data_in = 8'h00;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cart_bus_master_if bus ();

  cart_bus_master dut (
    .clk(clk), .rst(rst), .bus(bus),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
    .ppu_rd(ppu_rd), .ppu_wr(ppu_wr), .ppu_addr(ppu_addr), .ppu_not_a13(ppu_not_a13),
    .ppu_data_out(ppu_data_out), .ppu_data_oe(ppu_data_oe), .ppu_data_in(ppu_data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // /ROMSEL must never be asserted while M2 is low.
  always @(negedge clk) begin
    if (!rst) check("romsel_vs_m2", {31'd0, m2 | romsel}, 32'd1);
  end

  // Issue one request at ph 0 and observe the following eight clks.
  task automatic txn(input string tag, input logic ppu, input logic write,
                     input logic [15:0] addr, input logic [7:0] wdata, input logic [7:0] din,
                     input logic [7:0] e_romsel, input logic [7:0] e_rw, input logic [7:0] e_coe,
                     input logic [7:0] e_prd, input logic [7:0] e_pwr,
                     input logic [15:0] e_addr, input logic [7:0] e_rdata);
    logic [7:0]  v_m2, v_rs, v_rw, v_coe, v_prd, v_pwr, v_rsp;
    logic [15:0] a1;
    logic [7:0]  dout8;
    a1    = '0;
    dout8 = '0;
    check($sformatf("%s_ready", tag), {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_ppu   = ppu;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    cpu_data_in   = din;
    ppu_data_in   = din;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      v_m2[k]  = m2;
      v_rs[k]  = romsel;
      v_rw[k]  = cpu_rw;
      v_coe[k] = cpu_data_oe;
      v_prd[k] = ppu_rd;
      v_pwr[k] = ppu_wr;
      v_rsp[k] = bus.rsp_valid;
      if (k == 0) a1 = ppu ? {1'b0, ppu_not_a13, ppu_addr} : {1'b0, cpu_addr};
      if (k == 7) dout8 = ppu ? ppu_data_out : cpu_data_out;
    end
    check($sformatf("%s_m2", tag),     {24'd0, v_m2},  32'h78);
    check($sformatf("%s_romsel", tag), {24'd0, v_rs},  {24'd0, e_romsel});
    check($sformatf("%s_cpu_rw", tag), {24'd0, v_rw},  {24'd0, e_rw});
    check($sformatf("%s_cpu_oe", tag), {24'd0, v_coe}, {24'd0, e_coe});
    check($sformatf("%s_ppu_rd", tag), {24'd0, v_prd}, {24'd0, e_prd});
    check($sformatf("%s_ppu_wr", tag), {24'd0, v_pwr}, {24'd0, e_pwr});
    check($sformatf("%s_rsp", tag),    {24'd0, v_rsp}, 32'h80);
    check($sformatf("%s_addr", tag),   {16'd0, a1},    {16'd0, e_addr});
    check($sformatf("%s_rdata", tag),  {24'd0, bus.rsp_rdata}, {24'd0, e_rdata});
    if (write) check($sformatf("%s_wdata", tag), {24'd0, dout8}, {24'd0, wdata});
    $display("txn %s ppu=%0b wr=%0b addr=%h wdata=%h rdata=%h", tag, ppu, write, addr, wdata, bus.rsp_rdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_m2", tag),       {31'd0, m2},            32'd0);
    check($sformatf("%s_romsel", tag),   {31'd0, romsel},        32'd1);
    check($sformatf("%s_cpu_rw", tag),   {31'd0, cpu_rw},        32'd1);
    check($sformatf("%s_cpu_addr", tag), {17'd0, cpu_addr},      32'd0);
    check($sformatf("%s_cpu_dout", tag), {24'd0, cpu_data_out},  32'd0);
    check($sformatf("%s_cpu_oe", tag),   {31'd0, cpu_data_oe},   32'd0);
    check($sformatf("%s_ppu_rd", tag),   {31'd0, ppu_rd},        32'd1);
    check($sformatf("%s_ppu_wr", tag),   {31'd0, ppu_wr},        32'd1);
    check($sformatf("%s_ppu_na13", tag), {31'd0, ppu_not_a13},   32'd1);
    check($sformatf("%s_ppu_oe", tag),   {31'd0, ppu_data_oe},   32'd0);
    check($sformatf("%s_ready", tag),    {31'd0, bus.req_ready}, 32'd0);
    check($sformatf("%s_rsp", tag),      {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] v_m2, v_rdy, v_idle;
    bus.req_valid = 1'b0;
    bus.req_ppu   = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    $display("txn reset checked");

    rst = 1'b0;
    #1;
    check("idle_ready_ph0", {31'd0, bus.req_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v_m2[k]   = m2;
      v_rdy[k]  = bus.req_ready;
      v_idle[k] = romsel & cpu_rw & ppu_rd & ppu_wr & ~bus.rsp_valid;
    end
    check("idle_m2", {24'd0, v_m2}, 32'h78);
    check("idle_ready", {24'd0, v_rdy}, 32'h80);
    check("idle_lines", {24'd0, v_idle}, 32'hFF);
    $display("txn idle period m2=%h ready=%h", v_m2, v_rdy);

    //   tag          ppu wr  addr      wdata  din    romsel rw     coe    prd    pwr    e_addr    e_rdata
    txn("cpu_rd",     0,  0,  16'h8123, 8'h00, 8'h5A, 8'h87, 8'hFF, 8'h00, 8'hFF, 8'hFF, 16'h0123, 8'h5A);
    txn("cpu_wr",     0,  1,  16'h6000, 8'hA5, 8'hEE, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 16'h6000, 8'h5A);
    txn("ppu_rd",     1,  0,  16'h2400, 8'h00, 8'hC3, 8'hFF, 8'hFF, 8'h00, 8'h81, 8'hFF, 16'h2400, 8'hC3);
    txn("ppu_wr",     1,  1,  16'h0010, 8'h3C, 8'h11, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h81, 16'h4010, 8'hC3);
    txn("cpu_rd_fffc",0,  0,  16'hFFFC, 8'h00, 8'h34, 8'h87, 8'hFF, 8'h00, 8'hFF, 8'hFF, 16'h7FFC, 8'h34);
    txn("cpu_wr_8000",0,  1,  16'h8000, 8'h80, 8'h22, 8'h87, 8'h00, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 8'h34);
    txn("cpu_rd_4020",0,  0,  16'h4020, 8'h00, 8'h99, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 16'h4020, 8'h99);

    // Abort a CPU write to $8000 with reset at ph 5.
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_ppu   = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h8000;
    bus.req_wdata = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check("abort_pre_romsel", {31'd0, romsel}, 32'd0);
    check("abort_pre_oe", {31'd0, cpu_data_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_hold_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("abort_release_m2", {31'd0, m2}, 32'd0);
    $display("txn abort write $8000 at ph 5");
    txn("post_rst_rd",0,  0,  16'h8123, 8'h00, 8'h66, 8'h87, 8'hFF, 8'h00, 8'hFF, 8'hFF, 16'h0123, 8'h66);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_bus_master.md
# cart_bus_master

Famicom cartridge bus initiator that drives the CPU and PPU cartridge buses the way the console does. It turns a simple request/response handshake into correctly phased M2, /ROMSEL, R/W, address and data cycles, and into PPU /RD and /WR strobe cycles. It sits in the dumper/programmer and test-fixture designs, on the console side of the cartridge edge. M2 free-runs even when the block is idle, so cartridge logic clocked by M2 keeps running.

## Interface
Parameters:
- M2_LOW_CYCLES, default 4: clk cycles M2 is low per period; legal minimum 2.
- M2_HIGH_CYCLES, default 4: clk cycles M2 is high per period; legal minimum 1.

Period T = M2_LOW_CYCLES + M2_HIGH_CYCLES; L = M2_LOW_CYCLES.

Ports:
- clk  in  1  block clock; every output is registered on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  a request is present.
- req_ready  out  1  block accepts the request on this clk.
- req_ppu  in  1  0 = CPU-bus transaction, 1 = PPU-bus transaction.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  CPU address $0000-$FFFF, or PPU address in bits [13:0].
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse marking completion of a transaction.
- rsp_rdata  out  8  read data; holds until the next read completes.
- m2  out  1  CPU M2 clock.
- romsel  out  1  /ROMSEL.
- cpu_rw  out  1  CPU R/W (1 = read).
- cpu_addr  out  15  CPU A14..A0.
- cpu_data_out  out  8  CPU data driven by the block.
- cpu_data_oe  out  1  CPU data output enable.
- cpu_data_in  in  8  CPU data bus sampled by the block.
- ppu_rd  out  1  PPU /RD.
- ppu_wr  out  1  PPU /WR.
- ppu_addr  out  14  PPU A13..A0.
- ppu_not_a13  out  1  PPU /A13.
- ppu_data_out  out  8  PPU data driven by the block.
- ppu_data_oe  out  1  PPU data output enable.
- ppu_data_in  in  8  PPU data bus sampled by the block.

## Operation
- Phase counter ph counts 0..T-1 and wraps. The registered m2 output is high exactly while ph >= L.
- romsel is registered and equals ~(m2 & a15), where a15 is bit 15 of the active CPU address. It is never low while m2 is low, and always high during idle and PPU periods.
- req_ready = (ph == 0) & ~rst. Requests are accepted only on that clk, and only when req_valid is high.
- State machine:
  - IDLE → CPU on accept with req_ppu = 0.
  - IDLE → PPU on accept with req_ppu = 1.
  - CPU or PPU → IDLE at ph == 0 if no new request is accepted.
  - CPU or PPU → CPU or PPU directly if a new request is accepted at ph == 0. Back-to-back transactions are legal.
- CPU cycle:
  - At ph = 1: cpu_addr, a15, cpu_rw = ~req_write and cpu_data_out are loaded, and cpu_data_oe = req_write.
  - ph = L..T-1: m2 high; romsel low if a15 is set.
  - At ph = T-1: cpu_data_in is captured into rsp_rdata for reads.
- PPU cycle:
  - At ph = 1: ppu_addr, ppu_not_a13 = ~addr[13], ppu_data_out and ppu_data_oe = req_write are loaded.
  - ph = 2..T-1: ppu_rd (read) or ppu_wr (write) is held low.
  - At ph = T-1: ppu_data_in is captured for reads.
  - The CPU bus stays idle for the whole period.
- Release at the next ph = 0: rsp_valid = 1 for one clk, and strobes deassert.
- Hold at ph = 1: address, cpu_rw and the data enables hold through ph = 0. At ph = 1 they take the new request's values, or idle values if nothing was accepted: cpu_rw = 1, both oe = 0.
- Addresses keep their last value while idle.
- Reset values, forced asynchronously: m2 = 0, romsel = 1, cpu_rw = 1, cpu_addr = 0, cpu_data_oe = 0, ppu_rd = 1, ppu_wr = 1, ppu_addr = 0, ppu_not_a13 = 1, ppu_data_oe = 0, both data_out = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0, ph = 0, state IDLE.
- Reset asserted mid-transaction aborts it: no rsp_valid is produced. After release, operation restarts at ph = 0 with m2 low.

## Timing
- Latency: a request accepted at ph = 0 of period N completes with rsp_valid at ph = 0 of period N+1, i.e. exactly T clks.
- Throughput: one transaction per period; rsp_valid and the next acceptance may coincide.
- Address/R/W setup before m2 rises: L-1 clks. Hold after m2 falls: 1 clk.
- Write data valid from ph = 1 until ph = 1 of the next period, covering the m2 falling edge.
- Read sampling happens on the clk edge that ends the M2-high phase (or ends the PPU strobe). rsp_rdata is valid together with rsp_valid.
- Write transactions still pulse rsp_valid; rsp_rdata is unchanged.

## Test plan
- Reset release, no requests, defaults: m2 period 8 clks, 4 low / 4 high; romsel, cpu_rw, ppu_rd and ppu_wr stay 1; req_ready pulses every 8 clks.
- CPU read $8123, cpu_data_in = $5A: cpu_addr = $0123 from ph 1; romsel low only during ph 4-7; rsp_valid exactly 8 clks after accept; rsp_rdata = $5A.
- CPU write $6000 = $A5: romsel stays 1; cpu_rw = 0 and cpu_data_oe = 1 from ph 1 until ph 1 of the next period; data $A5 is stable at the m2 falling edge.
- PPU read $2400 then PPU write $0010 = $3C, back-to-back: ppu_not_a13 = 0 then 1; ppu_rd low in ph 2-7, then ppu_wr low in ph 2-7; two rsp_valid pulses 8 clks apart.
- Mixed back-to-back stream CPU read $FFFC, CPU write $8000 = $80, CPU read $4020: one rsp_valid per period; romsel never low while m2 is low; cpu_rw returns to 1 one clk after the write's m2 fall.
- Assert rst at ph 5 of a CPU write to $8000: all outputs go to reset values immediately and no rsp_valid is produced; after release, the first req_ready occurs at ph 0 and a new read completes normally.
